// File: rtl/fetch_decode_queue.sv
// IF/ID decoupling queue: buffers fetched instructions with their PC and splits the head into decode fields.
// Latency: an entry written at edge N appears on the decode outputs after edge N (no empty bypass).
// Backpressure: if_ready = !full, independent of id_ready; PCsrc flushes everything. Macro BRANCH_PREDECODE_EN adds is_branch.
module fetch_decode_queue #(
    parameter int INSTR_W = 24,
    parameter int PC_W    = 8,
    parameter int DEPTH   = 2
`ifdef BRANCH_PREDECODE_EN
    ,
    parameter logic [3:0] BRANCH_OPC = 4'hC
`endif
) (
    input  logic               CLK,
    input  logic               reset_n,
    input  logic [INSTR_W-1:0] Instr,
    input  logic [PC_W-1:0]    if_pc,
    input  logic               if_valid,
    output logic               if_ready,
    input  logic               PCsrc,
    input  logic               id_ready,
    output logic               id_valid,
    output logic [PC_W-1:0]    id_pc,
    output logic [3:0]         opcode,
    output logic [3:0]         rd,
    output logic [3:0]         rs1,
    output logic [3:0]         rs2,
    output logic [7:0]         imm
`ifdef BRANCH_PREDECODE_EN
    ,
    output logic               is_branch
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    entry_t          head;

    // Occupancy flags and handshakes; if_ready only looks at stored state, so
    // there is no combinational path from id_ready back to fetch.
    always_comb begin
        full     = (count == CW'(DEPTH));
        empty    = (count == '0);
        if_ready = ~full;
        id_valid = ~empty;
        push     = if_valid & if_ready & ~PCsrc;
        pop      = id_valid & id_ready & ~PCsrc;
        head     = mem[rd_ptr];
    end

    // Queue state: flush wins over push/pop; storage is left intact on flush
    // because it is unobservable while the queue reads empty.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (PCsrc) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{instr: Instr, pc: if_pc};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Decode field split of the head entry; everything reads zero while empty.
    always_comb begin
        id_pc  = '0;
        opcode = '0;
        rd     = '0;
        rs1    = '0;
        rs2    = '0;
        imm    = '0;
        if (id_valid) begin
            id_pc  = head.pc;
            opcode = head.instr[23:20];
            rd     = head.instr[19:16];
            rs1    = head.instr[15:12];
            rs2    = head.instr[11:8];
            imm    = head.instr[7:0];
        end
    end

`ifdef BRANCH_PREDECODE_EN
    // Early branch hint for the decode stage, qualified by a valid head.
    always_comb begin
        is_branch = id_valid & (opcode == BRANCH_OPC);
    end
`endif

endmodule
